// File: rtl/uart_pkg.sv
// Shared UART definitions: baud-rate encoding, oversample divisor helper and
// receiver state encoding, common to the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [1:0] {
    BAUD_9600   = 2'b00,
    BAUD_19200  = 2'b01,
    BAUD_57600  = 2'b10,
    BAUD_115200 = 2'b11
  } baudrate_select_t;

  localparam int BAUD_RATES [4] = '{9600, 19200, 57600, 115200};
  localparam int OVERSAMPLE     = 16;
  localparam int DATA_BITS      = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK_WAIT
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest.
  function automatic int baud_divisor(input int clock_hz, input logic [1:0] sel);
    int rate;
    rate = BAUD_RATES[sel];
    return (clock_hz + (OVERSAMPLE * rate) / 2) / (OVERSAMPLE * rate);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through byte buffer; a pop in the same cycle frees the slot
// for a push, so a full buffer only drops data when nobody is reading.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                           clock_i,
  input  logic                           reset_n_i,
  input  logic                           push,
  input  logic                           pop,
  input  logic [WIDTH-1:0]               data_in,
  output logic [WIDTH-1:0]               data_out,
  output logic                           empty,
  output logic                           full,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign count   = count_reg;

  // Head is forced to zero while empty so stale entries never appear.
  assign data_out = empty ? '0 : mem[rd_ptr_reg];

  always_ff @(posedge clock_i) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= data_in;
    end
  end

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: 16x oversampled 8N1 deserialiser with framing-error and
// break handling, feeding a first-word-fall-through receive buffer.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLOCK_FREQ_HZ     = 50000000,
  parameter int DATA_BUFFER_DEPTH = 16
) (
  input  logic                                   clock_i,
  input  logic                                   reset_n_i,
  input  logic                                   uart_rx_i,
  input  logic [1:0]                             baudrate_select_i,
  input  logic                                   data_read_i,
  output logic [7:0]                             data_o,
  output logic                                   data_buffer_empty_o,
  output logic [$clog2(DATA_BUFFER_DEPTH+1)-1:0] data_count_o,
  output logic                                   framing_error_o,
  output logic                                   overrun_o
);

  localparam int TICK_W   = $clog2(baud_divisor(CLOCK_FREQ_HZ, 2'b00) + 1);
  localparam int SAMPLE_W = $clog2(OVERSAMPLE);
  localparam int BIT_W    = $clog2(DATA_BITS);
  localparam int HALF_BIT = OVERSAMPLE / 2;

  logic [1:0]           rx_sync_reg;
  logic                 rx_bit;
  rx_state_t            state_reg, state_next;
  baudrate_select_t     baud_sel_reg, baud_sel_next;
  logic [TICK_W-1:0]    tick_cnt_reg, tick_cnt_next;
  logic [SAMPLE_W-1:0]  sample_cnt_reg, sample_cnt_next;
  logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 push_reg, push_next;
  logic                 framing_error_reg, framing_error_next;
  logic                 overrun_reg;
  logic [TICK_W-1:0]    div_last [4];
  logic [1:0]           active_sel;
  logic                 tick;
  logic                 fifo_full;

  for (genvar gi = 0; gi < 4; gi++) begin : g_div
    localparam int DIV = baud_divisor(CLOCK_FREQ_HZ, 2'(gi));
    assign div_last[gi] = TICK_W'(DIV - 1);
  end

  // The frame runs at the rate latched on start; idle follows the live select.
  assign active_sel = (state_reg == IDLE) ? baudrate_select_i : baud_sel_reg;
  assign tick       = (tick_cnt_reg == div_last[active_sel]);
  assign rx_bit     = rx_sync_reg[1];

  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rx_sync_reg       <= 2'b11;
      state_reg         <= IDLE;
      baud_sel_reg      <= BAUD_9600;
      tick_cnt_reg      <= '0;
      sample_cnt_reg    <= '0;
      bit_cnt_reg       <= '0;
      shift_reg         <= '0;
      push_reg          <= 1'b0;
      framing_error_reg <= 1'b0;
      overrun_reg       <= 1'b0;
    end else begin
      rx_sync_reg       <= {rx_sync_reg[0], uart_rx_i};
      state_reg         <= state_next;
      baud_sel_reg      <= baud_sel_next;
      tick_cnt_reg      <= tick_cnt_next;
      sample_cnt_reg    <= sample_cnt_next;
      bit_cnt_reg       <= bit_cnt_next;
      shift_reg         <= shift_next;
      push_reg          <= push_next;
      framing_error_reg <= framing_error_next;
      overrun_reg       <= push_reg && fifo_full && !data_read_i;
    end
  end

  always_comb begin
    state_next         = state_reg;
    baud_sel_next      = baud_sel_reg;
    tick_cnt_next      = tick ? '0 : tick_cnt_reg + 1'b1;
    sample_cnt_next    = sample_cnt_reg;
    bit_cnt_next       = bit_cnt_reg;
    shift_next         = shift_reg;
    push_next          = 1'b0;
    framing_error_next = 1'b0;

    case (state_reg)
      IDLE: begin
        if (!rx_bit) begin
          state_next      = START;
          baud_sel_next   = baudrate_select_t'(baudrate_select_i);
          tick_cnt_next   = '0;
          sample_cnt_next = '0;
          bit_cnt_next    = '0;
        end
      end
      START: begin
        if (tick) begin
          if (sample_cnt_reg == SAMPLE_W'(HALF_BIT - 1)) begin
            sample_cnt_next = '0;
            state_next      = rx_bit ? IDLE : DATA;
          end else begin
            sample_cnt_next = sample_cnt_reg + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sample_cnt_next = sample_cnt_reg + 1'b1;
          if (sample_cnt_reg == SAMPLE_W'(OVERSAMPLE - 1)) begin
            shift_next   = {rx_bit, shift_reg[DATA_BITS-1:1]};
            bit_cnt_next = bit_cnt_reg + 1'b1;
            if (bit_cnt_reg == BIT_W'(DATA_BITS - 1)) begin
              state_next = STOP;
            end
          end
        end
      end
      STOP: begin
        if (tick) begin
          sample_cnt_next = sample_cnt_reg + 1'b1;
          if (sample_cnt_reg == SAMPLE_W'(OVERSAMPLE - 1)) begin
            if (rx_bit) begin
              push_next  = 1'b1;
              state_next = IDLE;
            end else begin
              framing_error_next = 1'b1;
              state_next         = BREAK_WAIT;
            end
          end
        end
      end
      BREAK_WAIT: begin
        // A held-low line must return high before another start is accepted.
        if (rx_bit) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (DATA_BUFFER_DEPTH)
  ) u_fifo (
    .clock_i   (clock_i),
    .reset_n_i (reset_n_i),
    .push      (push_reg),
    .pop       (data_read_i),
    .data_in   (shift_reg),
    .data_out  (data_o),
    .empty     (data_buffer_empty_o),
    .full      (fifo_full),
    .count     (data_count_o)
  );

  assign framing_error_o = framing_error_reg;
  assign overrun_o       = overrun_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver: table of frames plus hand-written
// corner sequences, with a byte queue as the expected buffer contents.
module tb_uart_receiver;

  localparam int CLK_HZ = 6000000;
  localparam int DEPTH  = 16;
  localparam int CW     = $clog2(DEPTH + 1);
  // Expected divisors at 6 MHz: round(6e6 / (16 * baud)).
  localparam int DIV_TABLE [4] = '{39, 20, 7, 3};

  logic          clock_i = 1'b0;
  logic          reset_n_i = 1'b0;
  logic          uart_rx_i = 1'b1;
  logic [1:0]    baudrate_select_i = 2'b00;
  logic          data_read_i = 1'b0;
  logic [7:0]    data_o;
  logic          data_buffer_empty_o;
  logic [CW-1:0] data_count_o;
  logic          framing_error_o;
  logic          overrun_o;

  uart_receiver #(
    .CLOCK_FREQ_HZ     (CLK_HZ),
    .DATA_BUFFER_DEPTH (DEPTH)
  ) dut (
    .clock_i             (clock_i),
    .reset_n_i           (reset_n_i),
    .uart_rx_i           (uart_rx_i),
    .baudrate_select_i   (baudrate_select_i),
    .data_read_i         (data_read_i),
    .data_o              (data_o),
    .data_buffer_empty_o (data_buffer_empty_o),
    .data_count_o        (data_count_o),
    .framing_error_o     (framing_error_o),
    .overrun_o           (overrun_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    int         exp_count;
    int         pops;
  } vec_t;

  vec_t       vecs [6];
  logic [7:0] sb_q [$];
  int         tests = 0;
  int         fails = 0;
  int         ferr_seen = 0;
  int         ovr_seen = 0;

  always @(negedge clock_i) begin
    if (framing_error_o) ferr_seen++;
    if (overrun_o) ovr_seen++;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic [1:0] sel, input logic stop_bit);
    int bp;
    bp = 16 * DIV_TABLE[sel];
    baudrate_select_i = sel;
    @(negedge clock_i);
    uart_rx_i = 1'b0;
    repeat (bp) @(negedge clock_i);
    for (int i = 0; i < 8; i++) begin
      uart_rx_i = d[i];
      repeat (bp) @(negedge clock_i);
    end
    uart_rx_i = stop_bit;
    repeat (bp) @(negedge clock_i);
    $display("[TB] sent 0x%02h sel=%0d stop=%0b", d, sel, stop_bit);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] exp;
    @(negedge clock_i);
    if (sb_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL %s_underflow: got pop request, required a queued byte", tag);
      return;
    end
    exp = sb_q.pop_front();
    check({tag, "_empty"}, int'(data_buffer_empty_o), 0);
    check({tag, "_data"}, int'(data_o), int'(exp));
    $display("[TB] pop %s: data_o=0x%02h expected 0x%02h", tag, data_o, exp);
    data_read_i = 1'b1;
    @(negedge clock_i);
    data_read_i = 1'b0;
    check({tag, "_count"}, int'(data_count_o), sb_q.size());
  endtask

  initial begin
    int f0, o0;
    vecs[0] = '{8'hA5, 2'b11, 1, 1};
    vecs[1] = '{8'h00, 2'b00, 1, 0};
    vecs[2] = '{8'hFF, 2'b00, 2, 0};
    vecs[3] = '{8'h3C, 2'b00, 3, 3};
    vecs[4] = '{8'hC3, 2'b10, 1, 0};
    vecs[5] = '{8'h7E, 2'b01, 2, 2};

    repeat (4) @(negedge clock_i);
    check("rst_data", int'(data_o), 0);
    check("rst_empty", int'(data_buffer_empty_o), 1);
    check("rst_count", int'(data_count_o), 0);
    check("rst_ferr", int'(framing_error_o), 0);
    check("rst_ovr", int'(overrun_o), 0);
    reset_n_i = 1'b1;
    repeat (10) @(negedge clock_i);

    for (int v = 0; v < 6; v++) begin
      f0 = ferr_seen;
      o0 = ovr_seen;
      sb_q.push_back(vecs[v].data);
      send_frame(vecs[v].data, vecs[v].sel, 1'b1);
      check($sformatf("vec%0d_count", v), int'(data_count_o), vecs[v].exp_count);
      check($sformatf("vec%0d_empty", v), int'(data_buffer_empty_o), 0);
      check($sformatf("vec%0d_ferr", v), ferr_seen - f0, 0);
      check($sformatf("vec%0d_ovr", v), ovr_seen - o0, 0);
      for (int p = 0; p < vecs[v].pops; p++) pop_check($sformatf("vec%0d_pop%0d", v, p));
      check($sformatf("vec%0d_empty_after", v), int'(data_buffer_empty_o), (sb_q.size() == 0) ? 1 : 0);
    end

    // Short low glitch must not start a frame.
    f0 = ferr_seen;
    baudrate_select_i = 2'b11;
    @(negedge clock_i);
    uart_rx_i = 1'b0;
    repeat (10) @(negedge clock_i);
    uart_rx_i = 1'b1;
    repeat (96) @(negedge clock_i);
    check("fs_count", int'(data_count_o), 0);
    check("fs_ferr", ferr_seen - f0, 0);
    sb_q.push_back(8'h81);
    send_frame(8'h81, 2'b11, 1'b1);
    check("fs_count_after", int'(data_count_o), 1);
    pop_check("fs_81");

    // Bad stop bit followed by a long break.
    f0 = ferr_seen;
    o0 = ovr_seen;
    send_frame(8'h55, 2'b11, 1'b0);
    repeat (20 * 48) @(negedge clock_i);
    uart_rx_i = 1'b1;
    repeat (48) @(negedge clock_i);
    check("fe_pulses", ferr_seen - f0, 1);
    check("fe_count", int'(data_count_o), 0);
    check("fe_empty", int'(data_buffer_empty_o), 1);
    check("fe_ovr", ovr_seen - o0, 0);
    sb_q.push_back(8'h12);
    send_frame(8'h12, 2'b11, 1'b1);
    pop_check("fe_12");

    // Seventeen bytes into a sixteen-entry buffer.
    o0 = ovr_seen;
    for (int i = 1; i <= 17; i++) begin
      if (i <= 16) sb_q.push_back(8'(i));
      send_frame(8'(i), 2'b11, 1'b1);
      if (i == 16) check("ov_none_at_16", ovr_seen - o0, 0);
    end
    check("ov_count", int'(data_count_o), 16);
    check("ov_pulses", ovr_seen - o0, 1);
    for (int i = 0; i < 16; i++) pop_check($sformatf("ov_pop%0d", i));
    check("ov_empty", int'(data_buffer_empty_o), 1);

    // Full buffer with a pop on exactly the push cycle of the next byte.
    for (int i = 0; i < 16; i++) begin
      sb_q.push_back(8'h20 + 8'(i));
      send_frame(8'h20 + 8'(i), 2'b11, 1'b1);
    end
    check("fp_full", int'(data_count_o), 16);
    o0 = ovr_seen;
    fork
      send_frame(8'h99, 2'b11, 1'b1);
      begin
        @(negedge clock_i);
        repeat (3 + 152 * DIV_TABLE[3]) @(negedge clock_i);
        check("fp_count_before", int'(data_count_o), 16);
        check("fp_head", int'(data_o), 8'h20);
        data_read_i = 1'b1;
        @(negedge clock_i);
        data_read_i = 1'b0;
        void'(sb_q.pop_front());
        sb_q.push_back(8'h99);
        check("fp_count_after", int'(data_count_o), 16);
      end
    join
    check("fp_ovr", ovr_seen - o0, 0);
    for (int i = 0; i < 16; i++) pop_check($sformatf("fp_pop%0d", i));

    // Asynchronous reset in the middle of a frame.
    sb_q.push_back(8'h44);
    send_frame(8'h44, 2'b11, 1'b1);
    check("mr_count_pre", int'(data_count_o), 1);
    fork
      send_frame(8'h00, 2'b11, 1'b1);
      begin
        repeat (5 * 48) @(negedge clock_i);
        #2;
        reset_n_i = 1'b0;
        #1;
        check("mr_data", int'(data_o), 0);
        check("mr_empty", int'(data_buffer_empty_o), 1);
        check("mr_count", int'(data_count_o), 0);
        check("mr_ferr", int'(framing_error_o), 0);
        check("mr_ovr", int'(overrun_o), 0);
      end
    join
    sb_q.delete();
    repeat (4) @(negedge clock_i);
    reset_n_i = 1'b1;
    repeat (48) @(negedge clock_i);
    check("mr_count_idle", int'(data_count_o), 0);
    sb_q.push_back(8'h5A);
    send_frame(8'h5A, 2'b11, 1'b1);
    check("mr_count_post", int'(data_count_o), 1);
    pop_check("mr_5a");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
